uart_clk_rst_seq: RTL and testbench

//  Sequences bring-up of the UART subsystem on the fabric RC-oscillator clock (50 MHz, via CLKINT).
//  - Holds the UART peripheral in reset until the oscillator has run for a fixed startup window.
//  - Releases the peripheral reset synchronously, then generates the 16x-oversample baud tick.
//  - Divisor is reprogrammable at run time through a load/ack handshake.
//  - Sits between the oscillator wrapper and the UART core.

---
 rtl/uart_clk_pkg.sv | 22 ++
 rtl/uart_clk_rst_seq_rst_sync.sv | 22 ++
 rtl/uart_clk_rst_seq.sv | 167 ++++++++++++++++
 tb/tb_uart_clk_rst_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_clk_pkg.sv
// Shared encodings and defaults for the UART clock/reset sequencer.
package uart_clk_pkg;

    localparam int unsigned STATE_W                = 2;
    localparam int unsigned DIV_W_DEFAULT          = 16;
    localparam int unsigned DEFAULT_DIV_115200     = 27;
    localparam int unsigned STARTUP_CYCLES_DEFAULT = 1024;
    localparam int unsigned SYNC_STAGES_DEFAULT    = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD = 2'b00,
        ST_WAIT = 2'b01,
        ST_RUN  = 2'b10,
        ST_BAD  = 2'b11
    } seq_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_clk_rst_seq_rst_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts after STAGES clock edges.
module rst_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic rst_no
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign rst_no = sync_q[STAGES-1];

endmodule

// File: rtl/uart_clk_rst_seq.sv
// UART bring-up sequencer: startup hold-off, peripheral reset release and 16x baud tick
// generation with a run-time reprogrammable divisor.
module uart_clk_rst_seq
    import uart_clk_pkg::*;
#(
    parameter int unsigned STARTUP_CYCLES = STARTUP_CYCLES_DEFAULT,
    parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEFAULT,
    parameter int unsigned DIV_W          = DIV_W_DEFAULT,
    parameter int unsigned DEFAULT_DIV    = DEFAULT_DIV_115200
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               div_load_i,
    input  logic [DIV_W-1:0]   div_value_i,
    output logic               div_ack_o,
    output logic               div_err_o,
    output logic               periph_reset_n_o,
    output logic               ready_o,
    output logic               baud_tick_o,
    output logic [STATE_W-1:0] state_o
);

    localparam int unsigned     SU_W    = cnt_width(STARTUP_CYCLES);
    localparam logic [SU_W-1:0] SU_LAST = SU_W'(STARTUP_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

    logic rst_sync_n;

    rst_sync #(
        .STAGES(SYNC_STAGES)
    ) u_rst_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .rst_no(rst_sync_n)
    );

    seq_state_e       state_q, state_d;
    logic [SU_W-1:0]  su_cnt_q, su_cnt_d;
    logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             applied_q, applied_d;
    logic             ack_hold_q, ack_hold_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             tick_q, tick_d;

    logic in_run;
    logic wrap;
    logic load_ok;
    logic load_bad;
    logic ack_req;

    assign in_run   = (state_q == ST_RUN);
    assign wrap     = in_run && (baud_cnt_q == div_q - 1'b1);
    assign load_ok  = div_load_i && (div_value_i != '0);
    assign load_bad = div_load_i && (div_value_i == '0);

    always_comb begin
        state_d  = state_q;
        su_cnt_d = su_cnt_q;
        case (state_q)
            ST_HOLD: begin
                su_cnt_d = '0;
                if (rst_sync_n) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (su_cnt_q == SU_LAST) begin
                    state_d  = ST_RUN;
                    su_cnt_d = '0;
                end else begin
                    su_cnt_d = su_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                su_cnt_d = '0;
            end
            default: begin
                state_d  = ST_HOLD;
                su_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        baud_cnt_d = '0;
        if (in_run && !wrap) begin
            baud_cnt_d = baud_cnt_q + 1'b1;
        end
    end

    // Outside RUN a load takes effect at once; its ack follows one cycle later via applied_q.
    // In RUN the divisor only changes on a wrap so no period is ever truncated.
    always_comb begin
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        applied_d  = 1'b0;
        ack_req    = applied_q | ack_hold_q;
        if (in_run) begin
            if (wrap) begin
                if (load_ok) begin
                    div_d      = div_value_i;
                    pend_vld_d = 1'b0;
                    ack_req    = 1'b1;
                end else if (pend_vld_q) begin
                    div_d      = pend_q;
                    pend_vld_d = 1'b0;
                    ack_req    = 1'b1;
                end
            end else if (load_ok) begin
                pend_d     = div_value_i;
                pend_vld_d = 1'b1;
            end
        end else begin
            pend_vld_d = 1'b0;
            if (load_ok) begin
                div_d     = div_value_i;
                applied_d = 1'b1;
            end
        end
        err_d = load_bad;
        // An ack colliding with an error pulse is deferred by a cycle, never dropped.
        ack_d      = ack_req & ~err_d;
        ack_hold_d = ack_req & err_d;
        tick_d     = wrap;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_HOLD;
            su_cnt_q   <= '0;
            baud_cnt_q <= '0;
            div_q      <= DIV_RST;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            applied_q  <= 1'b0;
            ack_hold_q <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            su_cnt_q   <= su_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            applied_q  <= applied_d;
            ack_hold_q <= ack_hold_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            tick_q     <= tick_d;
        end
    end

    assign ready_o          = in_run;
    assign periph_reset_n_o = in_run;
    assign baud_tick_o      = tick_q;
    assign div_ack_o        = ack_q;
    assign div_err_o        = err_q;
    assign state_o          = (state_q == ST_BAD) ? ST_HOLD : state_q;

endmodule

// File: tb/tb_uart_clk_rst_seq.sv
// Directed bench for uart_clk_rst_seq with STARTUP_CYCLES=8, SYNC_STAGES=2, DEFAULT_DIV=27.
module tb_uart_clk_rst_seq;

    logic        clk;
    logic        rst_n;
    logic        div_load;
    logic [15:0] div_value;
    logic        div_ack;
    logic        div_err;
    logic        periph_rst_n;
    logic        ready;
    logic        baud_tick;
    logic [1:0]  state;

    int vec;
    int errs;

    uart_clk_rst_seq #(
        .STARTUP_CYCLES(8),
        .SYNC_STAGES   (2),
        .DIV_W         (16),
        .DEFAULT_DIV   (27)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .div_load_i      (div_load),
        .div_value_i     (div_value),
        .div_ack_o       (div_ack),
        .div_err_o       (div_err),
        .periph_reset_n_o(periph_rst_n),
        .ready_o         (ready),
        .baud_tick_o     (baud_tick),
        .state_o         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded search for the next tick; returns edges taken (200 on timeout).
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (baud_tick !== 1'b1 && n < 200);
    endtask

    // Releases reset from a point 1 time unit after an edge and checks the full bring-up.
    task automatic do_startup(input string tag);
        logic [1:0] exp_state;
        logic       exp_rdy;
        logic       exp_tick;
        rst_n = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            step();
            exp_rdy   = (e >= 11);
            exp_state = (e <= 2) ? 2'b00 : ((e <= 10) ? 2'b01 : 2'b10);
            vec++;
            if (ready !== exp_rdy || periph_rst_n !== exp_rdy) begin
                errs++;
                $display("FAIL %s release edge %0d: ready=%b periph=%b want %b", tag, e, ready,
                         periph_rst_n, exp_rdy);
            end
            vec++;
            if (state !== exp_state) begin
                errs++;
                $display("FAIL %s state edge %0d: got %b want %b", tag, e, state, exp_state);
            end
        end
        for (int k = 1; k <= 27; k++) begin
            step();
            exp_tick = (k == 27);
            vec++;
            if (baud_tick !== exp_tick) begin
                errs++;
                $display("FAIL %s first tick +%0d: got %b want %b", tag, k, baud_tick, exp_tick);
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        div_load  = 1'b0;
        div_value = '0;
        step();
        step();
        vec++;
        if ({ready, periph_rst_n, baud_tick, div_ack, div_err} !== 5'b0) begin
            errs++;
            $display("FAIL reset outputs: got %b want 00000",
                     {ready, periph_rst_n, baud_tick, div_ack, div_err});
        end
        vec++;
        if (state !== 2'b00) begin
            errs++;
            $display("FAIL reset state: got %b want 00", state);
        end
    endtask

    task automatic test_free_run();
        int n;
        for (int i = 0; i < 100; i++) begin
            step();
            vec++;
            if (baud_tick !== 1'b0) begin
                errs++;
                $display("FAIL tick width #%0d: got %b want 0", i, baud_tick);
            end
            wait_tick(n);
            vec++;
            if (n + 1 != 27) begin
                errs++;
                $display("FAIL tick spacing #%0d: got %0d want 27", i, n + 1);
            end
        end
    endtask

    // Entered on a tick cycle (k=0); zero divisor requested in cycle 5.
    task automatic test_div_err();
        logic exp_err;
        logic exp_tick;
        div_value = '0;
        for (int k = 1; k <= 54; k++) begin
            div_load = (k == 6);
            step();
            exp_err  = (k == 6);
            exp_tick = (k == 27 || k == 54);
            vec++;
            if (div_err !== exp_err || div_ack !== 1'b0) begin
                errs++;
                $display("FAIL div_err k=%0d: err=%b ack=%b want err=%b ack=0", k, div_err,
                         div_ack, exp_err);
            end
            vec++;
            if (baud_tick !== exp_tick) begin
                errs++;
                $display("FAIL div_err tick k=%0d: got %b want %b", k, baud_tick, exp_tick);
            end
        end
        div_load = 1'b0;
    endtask

    // Load 4 while the count reads 10: old period completes, then period 4.
    task automatic test_div_change();
        logic exp_ack;
        logic exp_tick;
        div_value = 16'd4;
        for (int k = 1; k <= 35; k++) begin
            div_load = (k == 11);
            step();
            exp_ack  = (k == 27);
            exp_tick = (k == 27 || k == 31 || k == 35);
            vec++;
            if (div_ack !== exp_ack || div_err !== 1'b0) begin
                errs++;
                $display("FAIL div_change k=%0d: ack=%b err=%b want ack=%b err=0", k, div_ack,
                         div_err, exp_ack);
            end
            vec++;
            if (baud_tick !== exp_tick) begin
                errs++;
                $display("FAIL div_change tick k=%0d: got %b want %b", k, baud_tick, exp_tick);
            end
        end
        div_load = 1'b0;
    endtask

    // Loads 6 then 3 while pending, then a rejected 0; one ack, new period 3.
    task automatic test_overwrite();
        logic exp_ack;
        logic exp_err;
        logic exp_tick;
        for (int k = 1; k <= 10; k++) begin
            div_load  = (k <= 3);
            div_value = (k == 1) ? 16'd6 : ((k == 2) ? 16'd3 : 16'd0);
            step();
            exp_err  = (k == 3);
            exp_ack  = (k == 4);
            exp_tick = (k == 4 || k == 7 || k == 10);
            vec++;
            if (div_ack !== exp_ack || div_err !== exp_err) begin
                errs++;
                $display("FAIL overwrite k=%0d: ack=%b err=%b want ack=%b err=%b", k, div_ack,
                         div_err, exp_ack, exp_err);
            end
            vec++;
            if (baud_tick !== exp_tick) begin
                errs++;
                $display("FAIL overwrite tick k=%0d: got %b want %b", k, baud_tick, exp_tick);
            end
        end
        div_load  = 1'b0;
        div_value = '0;
    endtask

    // Entered on a tick cycle: reset must clear outputs without waiting for an edge.
    task automatic test_reset_mid();
        #1;
        rst_n = 1'b0;
        #1;
        vec++;
        if ({ready, periph_rst_n, baud_tick, div_ack, div_err} !== 5'b0) begin
            errs++;
            $display("FAIL reset_mid async: got %b want 00000",
                     {ready, periph_rst_n, baud_tick, div_ack, div_err});
        end
        vec++;
        if (state !== 2'b00) begin
            errs++;
            $display("FAIL reset_mid state: got %b want 00", state);
        end
        step();
        step();
        do_startup("restart");
    endtask

    // Divisor 1 loaded in WAIT (cycle 4): ack in cycle 6, tick every cycle once running.
    task automatic test_wait_load();
        logic exp_ack;
        logic exp_rdy;
        logic exp_tick;
        rst_n = 1'b0;
        step();
        step();
        rst_n     = 1'b1;
        div_value = 16'd1;
        for (int e = 1; e <= 30; e++) begin
            div_load = (e == 5);
            step();
            exp_ack  = (e == 6);
            exp_rdy  = (e >= 11);
            exp_tick = (e >= 12);
            vec++;
            if (div_ack !== exp_ack || div_err !== 1'b0) begin
                errs++;
                $display("FAIL wait_load ack e=%0d: ack=%b err=%b want ack=%b err=0", e,
                         div_ack, div_err, exp_ack);
            end
            vec++;
            if (ready !== exp_rdy || baud_tick !== exp_tick) begin
                errs++;
                $display("FAIL wait_load run e=%0d: ready=%b tick=%b want ready=%b tick=%b",
                         e, ready, baud_tick, exp_rdy, exp_tick);
            end
        end
        div_load = 1'b0;
    endtask

    initial begin
        vec  = 0;
        errs = 0;
        test_reset();
        do_startup("startup");
        test_free_run();
        test_div_err();
        test_div_change();
        test_overwrite();
        test_reset_mid();
        test_wait_load();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
